line_dma_streamer: RTL and testbench

Consumes the dma_transmit_on control bit from the DMA-transmit CSR block and the scanner pixel stream.
- Packs 8-bit pixels four per 32-bit word.
- Frames each scan line as one Avalon-ST packet (SOP/EOP) for the downstream streaming DMA.
- Buffers words in a small FIFO, drops on backpressure overflow, and counts the drops.
- Enable/disable takes effect only on line boundaries, so the DMA never sees a partial packet.

---
 rtl/line_dma_pkg.sv | 23 ++
 rtl/sync_fifo_fwft.sv | 63 ++++++
 rtl/line_dma_streamer.sv | 125 ++++++++++++
 tb/tb_line_dma_streamer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_dma_pkg.sv
// Shared types and constants for the line DMA streamer.
// state_t       : streamer FSM states
// stream_word_t : one FIFO entry, {sop, eop, 32-bit packed pixels}
// PIX_PER_WORD  : 8-bit pixels packed per 32-bit word
// OVF_MAX       : saturation value of the dropped-word counter
package line_dma_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    PACK      = 2'd2
  } state_t;

  localparam int          PIX_PER_WORD = 4;
  localparam logic [15:0] OVF_MAX      = 16'hFFFF;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } stream_word_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : write push_data_i this cycle (ignored when full)
//   push_data_i  : entry to write
//   pop_i        : remove the head entry this cycle (ignored when empty)
//   head_o       : head entry, forced to zero while empty
//   empty_o      : no entries stored
//   free_o       : number of free entries (0..DEPTH)
module sync_fifo_fwft
  import line_dma_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = stream_word_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  T                       push_data_i,
  input  logic                   pop_i,
  output T                       head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] free_o
);

  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;
  logic           do_push;
  logic           do_pop;

  assign do_push = push_i && (count_q != (AW+1)'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  // Storage needs no reset: nothing is visible until count_q says so.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign empty_o = (count_q == '0);
  assign free_o  = (AW+1)'(DEPTH) - count_q;
  assign head_o  = empty_o ? T'('0) : mem_q[rd_ptr_q];

endmodule

// File: rtl/line_dma_streamer.sv
// Packs an 8-bit scanner pixel stream four pixels per 32-bit word and frames
// each scan line as one Avalon-ST packet (sop on the first word, eop on the
// last). Words pass through a small FWFT FIFO; words that cannot be admitted
// are dropped and counted. Enable changes only take effect on line boundaries.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   dma_transmit_on  : streaming enable from the CSR block
//   pix_data/_valid  : pixel sample and its qualifier
//   line_start       : first pixel of a line (qualified by pix_valid)
//   aso_*            : Avalon-ST source (data, valid, ready, sop, eop)
//   overflow_cnt     : saturating count of dropped words
//   busy             : FSM not idle or FIFO holds words
module line_dma_streamer
  import line_dma_pkg::*;
#(
  parameter int LINE_PIXELS = 2048,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_transmit_on,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  input  logic        line_start,
  output logic [31:0] aso_data,
  output logic        aso_valid,
  input  logic        aso_ready,
  output logic        aso_sop,
  output logic        aso_eop,
  output logic [15:0] overflow_cnt,
  output logic        busy
);

  localparam int CW = $clog2(LINE_PIXELS + 1);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;      // pixels accepted so far in this line
  logic [23:0]     pack_q;     // first three pixels of the word in progress
  logic [15:0]     ovf_q;

  logic [1:0]      pos;
  logic            word_done;
  logic            admit;
  logic            push;
  logic            reject;
  logic [FW-1:0]   need_free;
  logic [FW-1:0]   free;
  logic            fifo_empty;
  stream_word_t    wr_word;
  stream_word_t    head;

  always_comb begin
    pos          = cnt_q[1:0];
    word_done    = (state_q == PACK) && pix_valid && (pos == 2'd3);
    wr_word.sop  = (cnt_q < CW'(PIX_PER_WORD));
    wr_word.eop  = (cnt_q == CW'(LINE_PIXELS - 1));
    wr_word.data = {pix_data, pack_q};
    // A non-eop word must leave one slot free so an admitted sop can
    // always be closed by its eop.
    need_free    = wr_word.eop ? FW'(1) : FW'(2);
    admit        = (free >= need_free);
    push         = word_done && admit;
    reject       = word_done && !admit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pack_q  <= '0;
      ovf_q   <= '0;
    end else begin
      if (reject && (ovf_q != OVF_MAX)) ovf_q <= ovf_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (dma_transmit_on) state_q <= WAIT_LINE;
        end
        WAIT_LINE: begin
          if (!dma_transmit_on) begin
            state_q <= IDLE;
          end else if (pix_valid && line_start) begin
            pack_q  <= {16'h0000, pix_data};
            cnt_q   <= CW'(1);
            state_q <= PACK;
          end
        end
        PACK: begin
          if (pix_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (pos != 2'd3) pack_q[{pos, 3'b000} +: 8] <= pix_data;
            // A dropped sop discards the rest of the line.
            if (reject && wr_word.sop)
              state_q <= WAIT_LINE;
            else if (cnt_q == CW'(LINE_PIXELS - 1))
              state_q <= dma_transmit_on ? WAIT_LINE : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .T     (stream_word_t)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (wr_word),
    .pop_i       (aso_valid && aso_ready),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .free_o      (free)
  );

  assign aso_valid    = !fifo_empty;
  assign aso_data     = head.data;
  assign aso_sop      = head.sop;
  assign aso_eop      = head.eop;
  assign overflow_cnt = ovf_q;
  assign busy         = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_line_dma_streamer.sv
module tb_line_dma_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dma_on = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        line_start = 1'b0;
  logic        pv_s = 1'b0;
  logic        pv_l = 1'b0;
  logic        ready_s = 1'b1;
  logic        ready_l = 1'b1;

  logic [31:0] data_s, data_l;
  logic        valid_s, valid_l, sop_s, sop_l, eop_s, eop_l, busy_s, busy_l;
  logic [15:0] ovf_s, ovf_l;

  int tests_run = 0;
  int fails = 0;

  // {sop, eop, data}
  logic [33:0] exp_s_q[$];
  logic [33:0] exp_l_q[$];
  logic [33:0] mon_e;

  always #5 clk = ~clk;

  // Short-line DUT: 8 pixels per line, 4-entry FIFO
  line_dma_streamer #(.LINE_PIXELS(8), .FIFO_DEPTH(4)) dut_s (
    .clk(clk), .reset(reset), .dma_transmit_on(dma_on),
    .pix_data(pix_data), .pix_valid(pv_s), .line_start(line_start),
    .aso_data(data_s), .aso_valid(valid_s), .aso_ready(ready_s),
    .aso_sop(sop_s), .aso_eop(eop_s), .overflow_cnt(ovf_s), .busy(busy_s)
  );

  // Long-line DUT: 32 pixels per line, 4-entry FIFO
  line_dma_streamer #(.LINE_PIXELS(32), .FIFO_DEPTH(4)) dut_l (
    .clk(clk), .reset(reset), .dma_transmit_on(dma_on),
    .pix_data(pix_data), .pix_valid(pv_l), .line_start(line_start),
    .aso_data(data_l), .aso_valid(valid_l), .aso_ready(ready_l),
    .aso_sop(sop_l), .aso_eop(eop_l), .overflow_cnt(ovf_l), .busy(busy_l)
  );

  // Scoreboard: every accepted output word is checked against the queue.
  always @(negedge clk) begin
    if (!reset && valid_s && ready_s) begin
      tests_run++;
      if (exp_s_q.size() == 0) begin
        fails++;
        $display("FAIL pop_s: unexpected word sop=%0b eop=%0b data=%h", sop_s, eop_s, data_s);
      end else begin
        mon_e = exp_s_q.pop_front();
        if ({sop_s, eop_s, data_s} !== mon_e) begin
          fails++;
          $display("FAIL pop_s: got %h expected %h", {sop_s, eop_s, data_s}, mon_e);
        end
      end
    end
    if (!reset && valid_l && ready_l) begin
      tests_run++;
      if (exp_l_q.size() == 0) begin
        fails++;
        $display("FAIL pop_l: unexpected word sop=%0b eop=%0b data=%h", sop_l, eop_l, data_l);
      end else begin
        mon_e = exp_l_q.pop_front();
        if ({sop_l, eop_l, data_l} !== mon_e) begin
          fails++;
          $display("FAIL pop_l: got %h expected %h", {sop_l, eop_l, data_l}, mon_e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pix(input int sel, input logic [7:0] d, input logic ls);
    pix_data   = d;
    line_start = ls;
    if (sel == 0) pv_s = 1'b1;
    else          pv_l = 1'b1;
    tick(1);
    pv_s       = 1'b0;
    pv_l       = 1'b0;
    line_start = 1'b0;
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] base, input int k);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = base + 8'(4*k + j);
    return w;
  endfunction

  task automatic push_exp(input int sel, input logic [33:0] v);
    if (sel == 0) exp_s_q.push_back(v);
    else          exp_l_q.push_back(v);
  endtask

  task automatic send_line(input int sel, input int n, input logic [7:0] base, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      if (expect_out && (i % 4 == 3))
        push_exp(sel, {(i == 3), (i == n - 1), word_of(base, i / 4)});
      send_pix(sel, base + 8'(i), (i == 0));
    end
  endtask

  task automatic drain(input int sel);
    int n = 0;
    while (n < 300 && (sel == 0 ? (exp_s_q.size() != 0 || valid_s)
                                : (exp_l_q.size() != 0 || valid_l))) begin
      tick(1);
      n++;
    end
    tests_run++;
    if (n >= 300) begin
      fails++;
      $display("FAIL drain_%0d: timeout, %0d words still expected", sel,
               (sel == 0) ? exp_s_q.size() : exp_l_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    tests_run++;
    if ({valid_s, sop_s, eop_s, data_s, ovf_s, busy_s} !== 52'd0) begin
      fails++;
      $display("FAIL reset_s: outputs %h required 0", {valid_s, sop_s, eop_s, data_s, ovf_s, busy_s});
    end
    tests_run++;
    if ({valid_l, sop_l, eop_l, data_l, ovf_l, busy_l} !== 52'd0) begin
      fails++;
      $display("FAIL reset_l: outputs %h required 0", {valid_l, sop_l, eop_l, data_l, ovf_l, busy_l});
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_single_line();
    ready_s = 1'b1;
    dma_on  = 1'b1;
    tick(1);
    push_exp(0, {1'b1, 1'b0, 32'h04030201});
    push_exp(0, {1'b0, 1'b1, 32'h08070605});
    for (int i = 1; i <= 8; i++) begin
      send_pix(0, 8'(i), (i == 1));
      if (i == 3) begin
        tests_run++;
        if (valid_s !== 1'b0) begin
          fails++;
          $display("FAIL latency_early: aso_valid=%b required 0", valid_s);
        end
      end
      if (i == 4) begin
        tests_run++;
        if ({valid_s, sop_s, eop_s, data_s} !== {3'b110, 32'h04030201}) begin
          fails++;
          $display("FAIL latency_word0: got %h required %h", {valid_s, sop_s, eop_s, data_s},
                   {3'b110, 32'h04030201});
        end
      end
    end
    drain(0);
    tests_run++;
    if (ovf_s !== 16'd0) begin
      fails++;
      $display("FAIL single_ovf: overflow_cnt=%0d required 0", ovf_s);
    end
  endtask

  task automatic test_enable_mid_line();
    dma_on = 1'b0;
    tick(2);
    send_pix(0, 8'hA0, 1'b1);
    send_pix(0, 8'hA1, 1'b0);
    dma_on = 1'b1;
    for (int i = 2; i < 8; i++) send_pix(0, 8'hA0 + 8'(i), 1'b0);
    tests_run++;
    if (valid_s !== 1'b0) begin
      fails++;
      $display("FAIL enable_mid_line: aso_valid=%b required 0 before next line", valid_s);
    end
    send_line(0, 8, 8'h21, 1'b1);
    drain(0);
  endtask

  task automatic test_disable_mid_line();
    push_exp(0, {1'b1, 1'b0, word_of(8'h31, 0)});
    push_exp(0, {1'b0, 1'b1, word_of(8'h31, 1)});
    for (int i = 0; i < 8; i++) begin
      if (i == 3) dma_on = 1'b0;
      send_pix(0, 8'h31 + 8'(i), (i == 0));
    end
    drain(0);
    tick(1);
    tests_run++;
    if (busy_s !== 1'b0) begin
      fails++;
      $display("FAIL disable_busy: busy=%b required 0", busy_s);
    end
    send_line(0, 8, 8'h41, 1'b0);
    tick(3);
    tests_run++;
    if ({valid_s, busy_s} !== 2'b00) begin
      fails++;
      $display("FAIL disable_next_line: valid,busy=%b required 00", {valid_s, busy_s});
    end
  endtask

  task automatic test_overflow();
    ready_l = 1'b0;
    dma_on  = 1'b1;
    tick(1);
    push_exp(1, {1'b1, 1'b0, word_of(8'h40, 0)});
    push_exp(1, {1'b0, 1'b0, word_of(8'h40, 1)});
    push_exp(1, {1'b0, 1'b0, word_of(8'h40, 2)});
    push_exp(1, {1'b0, 1'b1, word_of(8'h40, 7)});
    send_line(1, 32, 8'h40, 1'b0);
    tests_run++;
    if (ovf_l !== 16'd4) begin
      fails++;
      $display("FAIL overflow_cnt: got %0d required 4", ovf_l);
    end
    tests_run++;
    if ({valid_l, sop_l, eop_l, data_l} !== {3'b110, word_of(8'h40, 0)}) begin
      fails++;
      $display("FAIL overflow_hold: got %h required %h", {valid_l, sop_l, eop_l, data_l},
               {3'b110, word_of(8'h40, 0)});
    end
    ready_l = 1'b1;
    drain(1);
  endtask

  task automatic test_sop_drop();
    ready_l = 1'b0;
    push_exp(1, {1'b1, 1'b0, word_of(8'h80, 0)});
    push_exp(1, {1'b0, 1'b0, word_of(8'h80, 1)});
    push_exp(1, {1'b0, 1'b0, word_of(8'h80, 2)});
    push_exp(1, {1'b0, 1'b1, word_of(8'h80, 7)});
    send_line(1, 32, 8'h80, 1'b0);
    // release exactly one word so three of four entries stay occupied
    ready_l = 1'b1;
    tick(1);
    ready_l = 1'b0;
    send_line(1, 32, 8'hC0, 1'b0);
    tests_run++;
    if (ovf_l !== 16'd9) begin
      fails++;
      $display("FAIL sop_drop_cnt: got %0d required 9", ovf_l);
    end
    ready_l = 1'b1;
    drain(1);
    send_line(1, 32, 8'h10, 1'b1);
    drain(1);
    tests_run++;
    if (ovf_l !== 16'd9) begin
      fails++;
      $display("FAIL sop_drop_after: got %0d required 9", ovf_l);
    end
  endtask

  task automatic test_reset_mid_packet();
    ready_s = 1'b0;
    dma_on  = 1'b1;
    tick(2);
    send_line(0, 8, 8'h51, 1'b0);
    for (int i = 0; i < 3; i++) send_pix(0, 8'h61 + 8'(i), (i == 0));
    tests_run++;
    if (valid_s !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_valid: aso_valid=%b required 1", valid_s);
    end
    reset = 1'b1;
    tick(1);
    tests_run++;
    if ({valid_s, sop_s, eop_s, data_s, ovf_s, busy_s} !== 52'd0) begin
      fails++;
      $display("FAIL mid_reset_s: outputs %h required 0", {valid_s, sop_s, eop_s, data_s, ovf_s, busy_s});
    end
    tests_run++;
    if ({valid_l, ovf_l, busy_l} !== 18'd0) begin
      fails++;
      $display("FAIL mid_reset_l: valid,ovf,busy %h required 0", {valid_l, ovf_l, busy_l});
    end
    reset   = 1'b0;
    ready_s = 1'b1;
    tick(1);
    send_line(0, 8, 8'h71, 1'b1);
    drain(0);
    tests_run++;
    if (ovf_s !== 16'd0) begin
      fails++;
      $display("FAIL post_reset_ovf: overflow_cnt=%0d required 0", ovf_s);
    end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_enable_mid_line();
    test_disable_mid_line();
    test_overflow();
    test_sop_drop();
    test_reset_mid_packet();
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
